rate_detector: RTL and testbench



---
 rtl/rate_pkg.sv | 41 ++++
 rtl/period_classifier.sv | 49 ++++
 rtl/rate_detector.sv | 137 +++++++++++++
 tb/tb_rate_detector.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rate_pkg.sv
// Shared types and helpers for the rate detector: speed codes, detector states and
// the nominal period / timeout arithmetic derived from the clock frequency.
package rate_pkg;

  typedef enum logic [1:0] {
    SPEED_FAST    = 2'b00,
    SPEED_1HZ     = 2'b01,
    SPEED_HALF    = 2'b10,
    SPEED_QUARTER = 2'b11
  } speed_t;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StTrack,
    StLocked
  } det_state_t;

  // Nominal pulse spacing in clock cycles for a given speed code.
  function automatic int unsigned nominal_period(speed_t code, int unsigned freq);
    int unsigned p;
    case (code)
      SPEED_FAST:    p = 1;
      SPEED_1HZ:     p = freq;
      SPEED_HALF:    p = 2 * freq;
      SPEED_QUARTER: p = 4 * freq;
      default:       p = 1;
    endcase
    return p;
  endfunction

  // Longest interval tracked before a missing pulse is declared.
  function automatic int unsigned tmax_cycles(int unsigned freq);
    return 4 * freq + 2;
  endfunction

  function automatic int unsigned period_width(int unsigned freq);
    return $clog2(4 * freq + 3);
  endfunction

endpackage

// File: rtl/period_classifier.sv
// Combinational decode of a measured pulse interval into a speed code.
// RATE_DETECT_TOLERANCE_EN widens the 01/10/11 windows to nominal +/-1 cycle.
module period_classifier
  import rate_pkg::*;
#(
  parameter int unsigned ClockFreq = 500,
  parameter int unsigned Width     = period_width(ClockFreq)
) (
  input  logic [Width-1:0] interval_i,
  output logic             match_o,
  output speed_t           code_o
);

`ifdef RATE_DETECT_TOLERANCE_EN
  localparam int unsigned Tol = 1;
`else
  localparam int unsigned Tol = 0;
`endif

  localparam int unsigned Nom1Hz  = nominal_period(SPEED_1HZ, ClockFreq);
  localparam int unsigned NomHalf = nominal_period(SPEED_HALF, ClockFreq);
  localparam int unsigned NomQtr  = nominal_period(SPEED_QUARTER, ClockFreq);

  localparam logic [Width-1:0] Lo1Hz  = Width'(Nom1Hz - Tol);
  localparam logic [Width-1:0] Hi1Hz  = Width'(Nom1Hz + Tol);
  localparam logic [Width-1:0] LoHalf = Width'(NomHalf - Tol);
  localparam logic [Width-1:0] HiHalf = Width'(NomHalf + Tol);
  localparam logic [Width-1:0] LoQtr  = Width'(NomQtr - Tol);
  localparam logic [Width-1:0] HiQtr  = Width'(NomQtr + Tol);
  localparam logic [Width-1:0] OneCyc = Width'(1);

  // Windows cannot overlap: ClockFreq >= 4 keeps F-1 well above the exact 1-cycle code.
  always_comb begin
    match_o = 1'b1;
    code_o  = SPEED_FAST;
    if (interval_i == OneCyc) begin
      code_o = SPEED_FAST;
    end else if (interval_i >= Lo1Hz && interval_i <= Hi1Hz) begin
      code_o = SPEED_1HZ;
    end else if (interval_i >= LoHalf && interval_i <= HiHalf) begin
      code_o = SPEED_HALF;
    end else if (interval_i >= LoQtr && interval_i <= HiQtr) begin
      code_o = SPEED_QUARTER;
    end else begin
      match_o = 1'b0;
    end
  end

endmodule

// File: rtl/rate_detector.sv
// Pulse-train rate detector: measures inter-pulse spacing, decodes it to a speed code,
// locks after two consecutive equal codes. Optional macro: RATE_DETECT_TOLERANCE_EN.
module rate_detector
  import rate_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 500,
  localparam int unsigned W = period_width(CLOCK_FREQUENCY)
) (
  input  logic         ClockIn,
  input  logic         Reset,
  input  logic         PulseIn,
  output logic [1:0]   SpeedOut,
  output logic         Locked,
  output logic         Valid,
  output logic [W-1:0] PeriodOut,
  output logic         Mismatch,
  output logic         Timeout
);

  localparam logic [W-1:0] TMax = W'(tmax_cycles(CLOCK_FREQUENCY));

  det_state_t     state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  speed_t         cand_q, cand_d;
  speed_t         speed_q, speed_d;
  logic [W-1:0]   period_q, period_d;
  logic           valid_q, valid_d;
  logic           mismatch_q, mismatch_d;
  logic           timeout_q, timeout_d;

  logic           cls_match;
  speed_t         cls_code;

  period_classifier #(
    .ClockFreq (CLOCK_FREQUENCY),
    .Width     (W)
  ) u_classifier (
    .interval_i (count_q),
    .match_o    (cls_match),
    .code_o     (cls_code)
  );

  // Cycles since the last pulse, counting the pulse edge as 1 and saturating at TMax.
  always_comb begin
    if (PulseIn) begin
      count_d = W'(1);
    end else if (count_q == TMax) begin
      count_d = count_q;
    end else begin
      count_d = count_q + W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    speed_d    = speed_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    mismatch_d = 1'b0;
    timeout_d  = 1'b0;

    if (PulseIn) begin
      if (state_q == StIdle) begin
        state_d = StMeasure;
      end else begin
        valid_d  = 1'b1;
        period_d = count_q;
        unique case (state_q)
          StMeasure: begin
            if (cls_match) begin
              state_d = StTrack;
              cand_d  = cls_code;
            end else begin
              mismatch_d = 1'b1;
            end
          end
          StTrack: begin
            if (cls_match && cls_code == cand_q) begin
              state_d = StLocked;
              speed_d = cand_q;
            end else if (cls_match) begin
              cand_d = cls_code;
            end else begin
              mismatch_d = 1'b1;
              state_d    = StMeasure;
            end
          end
          StLocked: begin
            if (cls_match && cls_code != cand_q) begin
              state_d = StTrack;
              cand_d  = cls_code;
            end else if (!cls_match) begin
              mismatch_d = 1'b1;
              state_d    = StMeasure;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end else if (state_q != StIdle && count_q == TMax) begin
      // Missing pulse: drop back to waiting for a fresh reference, keep last speed.
      timeout_d = 1'b1;
      state_d   = StIdle;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      cand_q     <= SPEED_FAST;
      speed_q    <= SPEED_FAST;
      period_q   <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cand_q     <= cand_d;
      speed_q    <= speed_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
    end
  end

  assign SpeedOut  = speed_q;
  assign Locked    = (state_q == StLocked);
  assign Valid     = valid_q;
  assign PeriodOut = period_q;
  assign Mismatch  = mismatch_q;
  assign Timeout   = timeout_q;

endmodule

// File: tb/tb_rate_detector.sv
// Self-checking bench for rate_detector: directed scenarios plus random pulse spacing,
// compared every cycle against a timestamp-based reference model.
module tb_rate_detector;

  localparam int F    = 500;
  localparam int W    = $clog2(4 * F + 3);
  localparam int TMAX = 4 * F + 2;
`ifdef RATE_DETECT_TOLERANCE_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 0;
`endif

  logic         ClockIn;
  logic         Reset;
  logic         PulseIn;
  logic [1:0]   SpeedOut;
  logic         Locked;
  logic         Valid;
  logic [W-1:0] PeriodOut;
  logic         Mismatch;
  logic         Timeout;

  rate_detector #(
    .CLOCK_FREQUENCY (F)
  ) dut (
    .ClockIn   (ClockIn),
    .Reset     (Reset),
    .PulseIn   (PulseIn),
    .SpeedOut  (SpeedOut),
    .Locked    (Locked),
    .Valid     (Valid),
    .PeriodOut (PeriodOut),
    .Mismatch  (Mismatch),
    .Timeout   (Timeout)
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: mode 0 idle, 1 measuring, 2 tracking, 3 locked.
  int m_mode   = 0;
  int m_cand   = 0;
  int m_speed  = 0;
  int m_period = 0;
  int m_valid  = 0;
  int m_mis    = 0;
  int m_to     = 0;
  int m_last   = -100000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Speed code whose nominal spacing matches the interval, or -1 if none.
  function automatic int classify(input int iv);
    if (iv == 1) return 0;
    for (int c = 1; c <= 3; c++) begin
      int nom;
      int diff;
      nom  = F * (1 << (c - 1));
      diff = (iv > nom) ? iv - nom : nom - iv;
      if (diff <= TOL) return c;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic p, input logic r);
    int iv;
    int c;
    cyc++;
    m_valid = 0;
    m_mis   = 0;
    m_to    = 0;
    if (r) begin
      m_mode   = 0;
      m_speed  = 0;
      m_period = 0;
      return;
    end
    iv = cyc - m_last;
    if (iv > TMAX) iv = TMAX;
    if (p) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        m_valid  = 1;
        m_period = iv;
        c        = classify(iv);
        if (c < 0) begin
          m_mis  = 1;
          m_mode = 1;
        end else if (m_mode == 1) begin
          m_mode = 2;
          m_cand = c;
        end else if (c == m_cand) begin
          if (m_mode == 2) m_speed = c;
          m_mode = 3;
        end else begin
          m_mode = 2;
          m_cand = c;
        end
      end
      m_last = cyc;
    end else if (m_mode != 0 && iv == TMAX) begin
      m_to   = 1;
      m_mode = 0;
    end
  endtask

  task automatic tick(input logic p, input logic r);
    PulseIn = p;
    Reset   = r;
    @(posedge ClockIn);
    model_edge(p, r);
    #1;
    check("Valid", 32'(Valid), 32'(m_valid));
    check("Mismatch", 32'(Mismatch), 32'(m_mis));
    check("Timeout", 32'(Timeout), 32'(m_to));
    check("Locked", 32'(Locked), 32'(m_mode == 3));
    check("SpeedOut", 32'(SpeedOut), 32'(m_speed));
    check("PeriodOut", 32'(PeriodOut), 32'(m_period));
  endtask

  // Next pulse lands exactly gap cycles after the previous one.
  task automatic pulse_after(input int gap);
    for (int i = 1; i < gap; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  initial begin
    PulseIn = 1'b0;
    Reset   = 1'b1;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("reset_period", 32'(PeriodOut), 32'd0);
    check("reset_speed", 32'(SpeedOut), 32'd0);

    // Continuous high: lock to code 00 after third high cycle.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check("cont_locked", 32'(Locked), 32'd1);
    check("cont_speed", 32'(SpeedOut), 32'd0);
    check("cont_period", 32'(PeriodOut), 32'd1);

    // 1000-cycle spacing locks to 10, 2000-cycle spacing relocks to 11.
    for (int i = 0; i < 3; i++) pulse_after(2 * F);
    check("half_speed", 32'(SpeedOut), 32'd2);
    check("half_period", 32'(PeriodOut), 32'(2 * F));
    pulse_after(4 * F);
    check("qtr_unlock", 32'(Locked), 32'd0);
    pulse_after(4 * F);
    check("qtr_locked", 32'(Locked), 32'd1);
    check("qtr_speed", 32'(SpeedOut), 32'd3);

    // Off-by-one spacing.
    pulse_after(F + 1);
`ifdef RATE_DETECT_TOLERANCE_EN
    check("tol_501_mis", 32'(Mismatch), 32'd0);
`else
    check("exact_501_mis", 32'(Mismatch), 32'd1);
`endif

    // Lock at 01, then stop pulses until timeout.
    for (int i = 0; i < 3; i++) pulse_after(F);
    check("hz_speed", 32'(SpeedOut), 32'd1);
    for (int i = 1; i < TMAX; i++) tick(1'b0, 1'b0);
    check("pre_timeout", 32'(Timeout), 32'd0);
    tick(1'b0, 1'b0);
    check("timeout_strobe", 32'(Timeout), 32'd1);
    check("timeout_speed", 32'(SpeedOut), 32'd1);
    tick(1'b0, 1'b0);

    // Reset coincident with a pulse while locked.
    tick(1'b1, 1'b0);
    pulse_after(F);
    pulse_after(F);
    check("relock", 32'(Locked), 32'd1);
    for (int i = 1; i < F; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check("rst_valid", 32'(Valid), 32'd0);
    check("rst_speed", 32'(SpeedOut), 32'd0);
    tick(1'b0, 1'b0);

    // Pulse exactly at saturation: classified, not a timeout.
    tick(1'b1, 1'b0);
    pulse_after(TMAX);
    check("sat_mis", 32'(Mismatch), 32'd1);
    check("sat_period", 32'(PeriodOut), 32'(TMAX));
    check("sat_timeout", 32'(Timeout), 32'd0);

    // Random spacing mix.
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) tick(1'($urandom_range(0, 1)), 1'b1);
      case (sel)
        0: pulse_after(1);
        1: pulse_after(F);
        2: pulse_after(2 * F);
        3: pulse_after(4 * F);
        4: pulse_after(F - 1);
        5: pulse_after(F + 1);
        6: pulse_after(2 * F + 1);
        7: pulse_after(4 * F - 1);
        8: pulse_after(int'($urandom_range(2, TMAX + 3)));
        default: for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
      endcase
    end
    tick(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
